// File: rtl/pc_sequencer.sv
// -----------------------------------------------------------------------------
// pc_sequencer
// Program-counter sequencer with increment, absolute jump, conditional relative
// branch, call/return through a small return-address stack, level halt, a
// program-load freeze and terminal fault reporting on stack over/underflow.
//
// Ports
//   clk_in     : rising-edge clock
//   rst        : synchronous active-high reset (pc=PROG_START, stack empty, RUN)
//   pgm        : program-load mode; freezes sequencing and state
//   halt       : level halt request
//   mem_ready  : instruction word at pc is available; a step may happen
//   br_mode    : 000 inc, 001 jump, 010 cond rel, 011 call, 100 return, else inc
//   br_cond    : branch condition for the relative mode
//   br_target  : absolute target for jump/call
//   br_off     : two's-complement relative offset
//   pc         : current program counter
//   pc_valid   : high while in RUN
//   depth      : occupied return-stack entries
//   fault      : bit0 sticky overflow, bit1 sticky underflow
//   state      : 00 RUN, 01 HALTED, 10 FAULT
// All outputs come straight from registers.
// -----------------------------------------------------------------------------
module pc_sequencer #(
    parameter int              PC_W        = 16,
    parameter int              OFF_W       = 7,
    parameter int              STACK_DEPTH = 4,
    parameter logic [PC_W-1:0] PROG_START  = 16'h000F
) (
    input  logic                             clk_in,
    input  logic                             rst,
    input  logic                             pgm,
    input  logic                             halt,
    input  logic                             mem_ready,
    input  logic [2:0]                       br_mode,
    input  logic                             br_cond,
    input  logic [PC_W-1:0]                  br_target,
    input  logic [OFF_W-1:0]                 br_off,
    output logic [PC_W-1:0]                  pc,
    output logic                             pc_valid,
    output logic [$clog2(STACK_DEPTH+1)-1:0] depth,
    output logic [1:0]                       fault,
    output logic [1:0]                       state
);

    localparam int DW = $clog2(STACK_DEPTH + 1);
    localparam int IW = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

    typedef enum logic [1:0] {
        ST_RUN    = 2'b00,
        ST_HALTED = 2'b01,
        ST_FAULT  = 2'b10
    } state_e;

    state_e            state_q, state_d;
    logic [PC_W-1:0]   pc_q, pc_d;
    logic [DW-1:0]     depth_q, depth_d;
    logic [1:0]        fault_q, fault_d;
    logic              pc_valid_q, pc_valid_d;

    logic [PC_W-1:0]   stack_q [STACK_DEPTH];

    logic [PC_W-1:0]   pc_inc_s;
    logic [PC_W-1:0]   off_ext_s;
    logic [IW-1:0]     push_idx_s;
    logic [IW-1:0]     pop_idx_s;
    logic              push_en_s;
    logic              stack_full_s;
    logic              stack_empty_s;
    logic              step_s;

    // Shared datapath terms: wrapped increment, sign-extended offset, stack pointers
    always_comb begin
        pc_inc_s      = pc_q + {{(PC_W-1){1'b0}}, 1'b1};
        off_ext_s     = PC_W'($signed(br_off));
        push_idx_s    = IW'(depth_q);
        pop_idx_s     = IW'(depth_q - {{(DW-1){1'b0}}, 1'b1});
        stack_full_s  = (depth_q == DW'(STACK_DEPTH));
        stack_empty_s = (depth_q == {DW{1'b0}});
        // pgm dominates halt and mem_ready; halt takes the edge with no step
        step_s        = (state_q == ST_RUN) && !pgm && !halt && mem_ready;
    end

    // Next-state, next-pc, stack push control and fault logic
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        depth_d   = depth_q;
        fault_d   = fault_q;
        push_en_s = 1'b0;

        case (state_q)
            ST_RUN: begin
                if (!pgm && halt) begin
                    state_d = ST_HALTED;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_HALTED: begin
                if (!pgm && !halt) begin
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_HALTED;
                end
            end
            ST_FAULT: begin
                state_d = ST_FAULT;
            end
            default: begin
                // Unreachable encoding: park safely in FAULT
                state_d = ST_FAULT;
            end
        endcase

        if (step_s) begin
            case (br_mode)
                3'b001: begin
                    pc_d = br_target;
                end
                3'b010: begin
                    if (br_cond) begin
                        pc_d = pc_inc_s + off_ext_s;
                    end else begin
                        pc_d = pc_inc_s;
                    end
                end
                3'b011: begin
                    if (stack_full_s) begin
                        // Overflow: pc holds, no push
                        fault_d[0] = 1'b1;
                        state_d    = ST_FAULT;
                    end else begin
                        push_en_s = 1'b1;
                        depth_d   = depth_q + {{(DW-1){1'b0}}, 1'b1};
                        pc_d      = br_target;
                    end
                end
                3'b100: begin
                    if (stack_empty_s) begin
                        fault_d[1] = 1'b1;
                        state_d    = ST_FAULT;
                    end else begin
                        depth_d = depth_q - {{(DW-1){1'b0}}, 1'b1};
                        pc_d    = stack_q[pop_idx_s];
                    end
                end
                default: begin
                    pc_d = pc_inc_s;
                end
            endcase
        end else begin
            pc_d = pc_q;
        end

        pc_valid_d = (state_d == ST_RUN);
    end

    // Control and pc registers with synchronous reset
    always_ff @(posedge clk_in) begin
        if (rst) begin
            state_q    <= ST_RUN;
            pc_q       <= PROG_START;
            depth_q    <= {DW{1'b0}};
            fault_q    <= 2'b00;
            pc_valid_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            depth_q    <= depth_d;
            fault_q    <= fault_d;
            pc_valid_q <= pc_valid_d;
        end
    end

    // Return-address storage; depth alone decides what is reachable, so no reset
    always_ff @(posedge clk_in) begin
        if (push_en_s && !rst) begin
            stack_q[push_idx_s] <= pc_inc_s;
        end
    end

    assign pc       = pc_q;
    assign pc_valid = pc_valid_q;
    assign depth    = depth_q;
    assign fault    = fault_q;
    assign state    = state_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// -----------------------------------------------------------------------------
// tb_pc_sequencer
// Scoreboard bench: each stimulus cycle runs a behavioural model (a queue used
// as the return stack, integer pc arithmetic) and pushes the expected outputs;
// a monitor pops one entry per clock and compares against the DUT.
// -----------------------------------------------------------------------------
module tb_pc_sequencer;

    localparam logic [15:0] START = 16'h000F;
    localparam int          SDEP  = 4;

    logic        clk_in = 1'b0;
    logic        rst = 1'b0, pgm = 1'b0, halt = 1'b0, mem_ready = 1'b0;
    logic [2:0]  br_mode = 3'b000;
    logic        br_cond = 1'b0;
    logic [15:0] br_target = 16'h0000;
    logic [6:0]  br_off = 7'h00;
    logic [15:0] pc;
    logic        pc_valid;
    logic [2:0]  depth;
    logic [1:0]  fault;
    logic [1:0]  state;

    typedef struct packed {
        logic [15:0] pc;
        logic [2:0]  depth;
        logic [1:0]  fault;
        logic [1:0]  state;
        logic        valid;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model state
    logic [15:0] m_pc = START;
    int          m_stack[$];
    logic [1:0]  m_fault = 2'b00;
    int          m_state = 0; // 0 RUN, 1 HALTED, 2 FAULT

    pc_sequencer dut (
        .clk_in(clk_in), .rst(rst), .pgm(pgm), .halt(halt), .mem_ready(mem_ready),
        .br_mode(br_mode), .br_cond(br_cond), .br_target(br_target), .br_off(br_off),
        .pc(pc), .pc_valid(pc_valid), .depth(depth), .fault(fault), .state(state)
    );

    always #5 clk_in = ~clk_in;

    task automatic model_edge();
        if (rst) begin
            m_pc = START;
            m_stack.delete();
            m_fault = 2'b00;
            m_state = 0;
        end else if (m_state == 0) begin
            if (pgm) begin
                m_state = 0;
            end else if (halt) begin
                m_state = 1;
            end else if (mem_ready) begin
                case (br_mode)
                    3'd1: m_pc = br_target;
                    3'd2: m_pc = 16'(int'(m_pc) + 1 + (br_cond ? int'($signed(br_off)) : 0));
                    3'd3: begin
                        if (m_stack.size() < SDEP) begin
                            m_stack.push_back(int'(16'(int'(m_pc) + 1)));
                            m_pc = br_target;
                        end else begin
                            m_fault[0] = 1'b1;
                            m_state = 2;
                        end
                    end
                    3'd4: begin
                        if (m_stack.size() > 0) begin
                            m_pc = 16'(m_stack.pop_back());
                        end else begin
                            m_fault[1] = 1'b1;
                            m_state = 2;
                        end
                    end
                    default: m_pc = 16'(int'(m_pc) + 1);
                endcase
            end
        end else if (m_state == 1) begin
            if (!pgm && !halt) m_state = 0;
        end
    endtask

    task automatic cyc(input logic r, input logic p, input logic h, input logic m,
                       input logic [2:0] mode, input logic c,
                       input logic [15:0] t, input logic [6:0] o);
        exp_t e;
        @(negedge clk_in);
        rst = r; pgm = p; halt = h; mem_ready = m;
        br_mode = mode; br_cond = c; br_target = t; br_off = o;
        @(posedge clk_in);
        model_edge();
        e.pc    = m_pc;
        e.depth = 3'(m_stack.size());
        e.fault = m_fault;
        e.state = 2'(m_state);
        e.valid = (m_state == 0);
        exp_q.push_back(e);
    endtask

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: actual %h required %h at %0t", name, act, req, $time);
        end
    endtask

    // Monitor: the DUT presents a registered result every clock
    initial begin
        exp_t e;
        forever begin
            @(posedge clk_in);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("pc",       int'(pc),       int'(e.pc));
                chk("depth",    int'(depth),    int'(e.depth));
                chk("fault",    int'(fault),    int'(e.fault));
                chk("state",    int'(state),    int'(e.state));
                chk("pc_valid", int'(pc_valid), int'(e.valid));
            end
        end
    end

    // Stimulus: directed scenarios followed by randomized traffic
    initial begin
        // Reset, three increments, one stall
        cyc(1'b1, 1'b0, 1'b0, 1'b1, 3'd0, 1'b0, 16'h0000, 7'h00);
        repeat (3) cyc(1'b0, 1'b0, 1'b0, 1'b1, 3'd0, 1'b0, 16'h0000, 7'h00);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 3'd1, 1'b0, 16'h1234, 7'h00);
        // Relative branches and wrap
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 3'd1, 1'b0, 16'h0020, 7'h00);
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 3'd2, 1'b1, 16'h0000, 7'h7E);
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 3'd1, 1'b0, 16'h0020, 7'h00);
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 3'd2, 1'b0, 16'h0000, 7'h7E);
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 3'd1, 1'b0, 16'hFFFF, 7'h00);
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 3'd0, 1'b0, 16'h0000, 7'h00);
        // Nested call/return
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 3'd1, 1'b0, 16'h0010, 7'h00);
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 3'd3, 1'b0, 16'h0100, 7'h00);
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 3'd3, 1'b0, 16'h0200, 7'h00);
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 3'd4, 1'b0, 16'h0000, 7'h00);
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 3'd4, 1'b0, 16'h0000, 7'h00);
        // Overflow on fifth call, ignored steps, reset recovery
        cyc(1'b1, 1'b0, 1'b0, 1'b1, 3'd0, 1'b0, 16'h0000, 7'h00);
        for (int i = 1; i <= 5; i++)
            cyc(1'b0, 1'b0, 1'b0, 1'b1, 3'd3, 1'b0, 16'(i * 256), 7'h00);
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 3'd0, 1'b0, 16'h0000, 7'h00);
        cyc(1'b0, 1'b0, 1'b1, 1'b1, 3'd4, 1'b0, 16'h0000, 7'h00);
        cyc(1'b1, 1'b0, 1'b0, 1'b1, 3'd0, 1'b0, 16'h0000, 7'h00);
        // Underflow, then halt / pgm behaviour
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 3'd4, 1'b0, 16'h0000, 7'h00);
        cyc(1'b1, 1'b0, 1'b0, 1'b1, 3'd0, 1'b0, 16'h0000, 7'h00);
        repeat (2) cyc(1'b0, 1'b0, 1'b1, 1'b1, 3'd0, 1'b0, 16'h0000, 7'h00);
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 3'd0, 1'b0, 16'h0000, 7'h00);
        cyc(1'b0, 1'b1, 1'b1, 1'b1, 3'd0, 1'b0, 16'h0000, 7'h00);
        cyc(1'b0, 1'b0, 1'b1, 1'b1, 3'd0, 1'b0, 16'h0000, 7'h00);
        cyc(1'b0, 1'b1, 1'b0, 1'b1, 3'd0, 1'b0, 16'h0000, 7'h00);
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 3'd0, 1'b0, 16'h0000, 7'h00);
        // Randomized traffic, call/return weighted so the stack gets exercised
        for (int i = 0; i < 3000; i++) begin
            logic [2:0] md;
            md = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 3) == 0) md = ($urandom_range(0, 1) == 0) ? 3'd3 : 3'd4;
            cyc(($urandom_range(0, 39) == 0),
                ($urandom_range(0, 15) == 0),
                ($urandom_range(0, 9) == 0),
                ($urandom_range(0, 7) != 0),
                md, 1'($urandom), 16'($urandom), 7'($urandom));
        end
        @(negedge clk_in);
        rst = 1'b0; pgm = 1'b1;
        repeat (3) @(posedge clk_in);
        #2;
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 SHALL have parameter PC_W, default 16, program-counter width.
REQ-002 SHALL have parameter OFF_W, default 7, signed relative-branch offset width (2 <= OFF_W <= PC_W).
REQ-003 SHALL have parameter STACK_DEPTH, default 4, return-stack entries (>= 1).
REQ-004 SHALL have parameter PROG_START, default 16'h000F, reset/restart PC value.
REQ-005 SHALL have one clock and a synchronous active-high reset: clk_in input 1, rising-edge clock; rst input 1, synchronous active-high reset.
REQ-006 pgm  input  1  program-load mode; freezes sequencing.
REQ-007 halt  input  1  level halt request.
REQ-008 mem_ready  input  1  instruction memory has delivered the word at pc; step permitted.
REQ-009 br_mode  input  3  000 inc, 001 jump abs, 010 cond rel, 011 call, 100 return, others = inc.
REQ-010 br_cond  input  1  condition for mode 010.
REQ-011 br_target  input  PC_W  absolute target for 001/011.
REQ-012 br_off  input  OFF_W  two's-complement offset for 010.
REQ-013 pc  output  PC_W  current program counter.
REQ-014 pc_valid  output  1  high when state is RUN.
REQ-015 depth  output  $clog2(STACK_DEPTH+1)  occupied return-stack entries.
REQ-016 fault  output  2  bit0 sticky overflow, bit1 sticky underflow.
REQ-017 state  output  2  00 RUN, 01 HALTED, 10 FAULT.

Function
REQ-018 A step SHALL occur on a rising edge when state=RUN, pgm=0, halt=0, mem_ready=1; otherwise pc, stack and depth hold.
REQ-019 Step, mode 000 or undefined: pc <= pc+1, modulo 2^PC_W (all-ones wraps to 0).
REQ-020 Step, mode 001: pc <= br_target.
REQ-021 Step, mode 010, br_cond=1: pc <= pc+1+sign_extend(br_off), modulo 2^PC_W; br_cond=0: pc <= pc+1.
REQ-022 Step, mode 011, depth<STACK_DEPTH: push pc+1 (wrapped), depth+1, pc <= br_target.
REQ-023 Step, mode 011, depth=STACK_DEPTH: no push, pc holds, fault[0] <= 1, state <= FAULT.
REQ-024 Step, mode 100, depth>0: pc <= top entry, depth-1.
REQ-025 Step, mode 100, depth=0: pc holds, fault[1] <= 1, state <= FAULT.
REQ-026 Stack SHALL be LIFO; a pop after push returns the most recently pushed value; entries above depth are don't-care.
REQ-027 RUN -> HALTED when halt=1 and pgm=0 at an edge (no step that edge); HALTED -> RUN when halt=0 at an edge; pc unchanged across halt.
REQ-028 FAULT SHALL be terminal until rst; pc, depth, fault hold; pc_valid=0.
REQ-029 pgm=1 SHALL dominate halt and mem_ready: no step, no state change, from RUN or HALTED.
REQ-030 mem_ready=0 in RUN SHALL stall with no side effect; pc_valid stays 1.
REQ-031 All outputs SHALL be registered or decoded from registered state only; no combinational path from inputs to outputs.

Reset
REQ-032 rst=1 at an edge SHALL force pc=PROG_START, depth=0, fault=00, state=RUN, pc_valid=1, dominating every other input including mid-call/mid-halt/FAULT.
REQ-033 Stack contents need not be cleared; depth=0 makes them unreachable.

Verification
REQ-034 rst, then 3 steps mode 000 -> pc 000F,0010,0011,0012; mem_ready=0 one cycle -> pc holds 0012.
REQ-035 pc=0020, mode 010, br_off=7'h7E, br_cond=1 -> pc=001F; br_cond=0 -> pc=0021; pc=FFFF mode 000 -> 0000.
REQ-036 pc=0010 call 0100, at 0100 call 0200, return, return -> pc 0100,0200,0101,0011; depth 1,2,1,0.
REQ-037 STACK_DEPTH=4: five nested calls -> fifth leaves pc unchanged, fault=01, state=FAULT, pc_valid=0; further steps ignored; rst -> RUN, pc=000F.
REQ-038 return with depth=0 -> fault=10, state=FAULT; halt=1 two cycles -> HALTED, pc held, halt=0 -> RUN; pgm=1 with halt=1 -> state unchanged.
